// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R scrambler constants and next-state/output function.
// Used by the transmit scrambler and the receive descrambler.
package pcs_pkg;

  localparam int PCS_DATA_W  = 64;
  localparam int SCR_STATE_W = 58;
  localparam int SCR_TAP_A   = 39;
  localparam int SCR_TAP_B   = 58;

  localparam int SCR_EXT_W = SCR_STATE_W + PCS_DATA_W;

  // Returns {new_state, scrambled_word}.
  // x[57:0] is the old state (oldest bit at 0); x[58+j] is out bit j.
  // Out bit j sees X(j-39) at x[58+j-39] and X(j-58) at x[58+j-58].
  function automatic logic [SCR_STATE_W+PCS_DATA_W-1:0] scr_next(
    input logic [SCR_STATE_W-1:0] state,
    input logic [PCS_DATA_W-1:0]  data
  );
    logic [SCR_EXT_W-1:0] x;
    x = '0;
    x[SCR_STATE_W-1:0] = state;
    for (int j = 0; j < PCS_DATA_W; j++) begin
      x[SCR_STATE_W+j] = data[j]
                       ^ x[SCR_STATE_W+j-SCR_TAP_A]
                       ^ x[SCR_STATE_W+j-SCR_TAP_B];
    end
    return {x[SCR_EXT_W-1:PCS_DATA_W], x[SCR_EXT_W-1:SCR_STATE_W]};
  endfunction

endpackage

// File: rtl/pcs_scrambler.sv
// 10GBASE-R TX self-synchronous scrambler, G(x) = 1 + x^39 + x^58.
// Ports: clk, rst (async active-low), in_data/in_data_valid in,
// out_data/out_data_valid registered out (1-cycle latency).
// Option PCS_SCRAMBLER_BYPASS_EN adds input bypass: pass data
// unscrambled while the scrambler state keeps advancing.
module pcs_scrambler
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef PCS_SCRAMBLER_BYPASS_EN
  input  logic                  bypass,
`endif
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_data_valid
);

  if (DATA_WIDTH != PCS_DATA_W) begin : g_width_chk
    $error("pcs_scrambler: DATA_WIDTH must be 64");
  end

  logic [SCR_STATE_W-1:0] r_state;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_valid;

  logic [SCR_STATE_W-1:0] w_state_nxt;
  logic [DATA_WIDTH-1:0]  w_scr;
  logic [DATA_WIDTH-1:0]  w_out;

  always_comb begin
    {w_state_nxt, w_scr} = scr_next(r_state, in_data);
  end

`ifdef PCS_SCRAMBLER_BYPASS_EN
  assign w_out = bypass ? in_data : w_scr;
`else
  assign w_out = w_scr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_data_valid;
      if (in_data_valid) begin
        r_state <= w_state_nxt;
        r_data  <= w_out;
      end
    end
  end

  assign out_data       = r_data;
  assign out_data_valid = r_valid;

endmodule

// File: tb/tb_pcs_scrambler.sv
// Directed bench for pcs_scrambler: impulse, carry-over,
// zero stream, descrambler round trip and mid-stream reset.
module tb_pcs_scrambler;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic        in_data_valid;
  logic [63:0] out_data;
  logic        out_data_valid;
`ifdef PCS_SCRAMBLER_BYPASS_EN
  logic        bypass;
`endif

  int n_chk;
  int n_fail;

  pcs_scrambler #(.DATA_WIDTH(64)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef PCS_SCRAMBLER_BYPASS_EN
    .bypass         (bypass),
`endif
    .in_data        (in_data),
    .in_data_valid  (in_data_valid),
    .out_data       (out_data),
    .out_data_valid (out_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_data_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Reference descrambler: y[j] = c[j] ^ c[j-39] ^ c[j-58].
  function automatic logic [63:0] descr(input logic [63:0] cur,
                                        input logic [63:0] prev);
    logic [127:0] c;
    logic [63:0]  y;
    c = {cur, prev};
    for (int j = 0; j < 64; j++)
      y[j] = c[64+j] ^ c[64+j-39] ^ c[64+j-58];
    return y;
  endfunction

  logic [63:0] rt_w [3];
  logic [63:0] prev;

  initial begin
    n_chk = 0;
    n_fail = 0;
`ifdef PCS_SCRAMBLER_BYPASS_EN
    bypass = 1'b0;
`endif
    rt_w[0] = 64'h78D5_5555_5555_5555;
    rt_w[1] = 64'hBBAA_5544_3322_1100;
    rt_w[2] = 64'hCC71_3B28_B207_0707;

    // Reset with valid data presented: must be ignored.
    rst = 1'b0;
    in_data = '1;
    in_data_valid = 1'b1;
    step();
    step();
    chk("rst_data", out_data, 64'h0);
    chk("rst_valid", {63'h0, out_data_valid}, 64'h0);

    // Impulse, then zero word back-to-back.
    rst = 1'b1;
    in_data = 64'h1;
    in_data_valid = 1'b1;
    step();
    chk("imp_data", out_data, 64'h0400_0080_0000_0001);
    chk("imp_valid", {63'h0, out_data_valid}, 64'h1);
    in_data = 64'h0;
    step();
    chk("carry_data", out_data, 64'h0030_0000_0000_4000);
    chk("carry_valid", {63'h0, out_data_valid}, 64'h1);
    in_data_valid = 1'b0;
    in_data = 64'hDEAD_BEEF_0000_0001;
    step();
    chk("idle_valid", {63'h0, out_data_valid}, 64'h0);
    chk("idle_hold", out_data, 64'h0030_0000_0000_4000);

    // Async reset clears outputs before any edge.
    rst = 1'b0;
    #1;
    chk("async_rst", out_data, 64'h0);
    step();
    rst = 1'b1;

    // Impulse, 3 idle cycles, zero word.
    in_data = 64'h1;
    in_data_valid = 1'b1;
    step();
    chk("gap_imp", out_data, 64'h0400_0080_0000_0001);
    in_data_valid = 1'b0;
    in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_idle_v", {63'h0, out_data_valid}, 64'h0);
    end
    chk("gap_hold", out_data, 64'h0400_0080_0000_0001);
    in_data = 64'h0;
    in_data_valid = 1'b1;
    step();
    chk("gap_carry", out_data, 64'h0030_0000_0000_4000);
    chk("gap_carry_v", {63'h0, out_data_valid}, 64'h1);

    // Zero stream from reset.
    do_reset();
    in_data = 64'h0;
    in_data_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("zero_stream", out_data, 64'h0);
    end

    // Round trip with idle gaps.
    do_reset();
    prev = 64'h0;
    for (int i = 0; i < 3; i++) begin
      in_data = rt_w[i];
      in_data_valid = 1'b1;
      step();
      chk("rt_valid", {63'h0, out_data_valid}, 64'h1);
      chk("rt_data", descr(out_data, prev), rt_w[i]);
      prev = out_data;
      in_data_valid = 1'b0;
      step();
      step();
    end

    // Mid-stream reset between words 2 and 3.
    do_reset();
    prev = 64'h0;
    for (int i = 0; i < 2; i++) begin
      in_data = rt_w[i];
      in_data_valid = 1'b1;
      step();
      chk("mid_pre", descr(out_data, prev), rt_w[i]);
      prev = out_data;
    end
    do_reset();
    in_data = rt_w[2];
    in_data_valid = 1'b1;
    step();
    chk("mid_post", descr(out_data, 64'h0), rt_w[2]);
    chk("mid_post_v", {63'h0, out_data_valid}, 64'h1);
    in_data_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
